// File: rtl/regbank_arbiter.sv
// regbank_arbiter: serialises write and two read requesters onto one single-port register bank
module regbank_arbiter #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 4,
    parameter int BANK_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    input  logic              rda_req,
    input  logic [ADDR_W-1:0] rda_addr,
    output logic [DATA_W-1:0] rda_data,
    output logic              rda_ack,
    input  logic              rdb_req,
    input  logic [ADDR_W-1:0] rdb_addr,
    output logic [DATA_W-1:0] rdb_data,
    output logic              rdb_ack,
    output logic [ADDR_W-1:0] bank_addr,
    output logic [DATA_W-1:0] bank_wdata,
    input  logic [DATA_W-1:0] bank_rdata,
    output logic              bank_trigger,
    output logic              bank_rw,
    output logic              busy
);
    localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, ACK = 2'd2;
    localparam logic [1:0] SRC_WR = 2'd0, SRC_A = 2'd1, SRC_B = 2'd2;
    localparam logic [3:0] CNT_INIT = 4'(BANK_LAT - 1);
    logic [1:0] state;
    logic [1:0] src;
    logic [3:0] cnt;
    logic       rr_last;
    logic       pick_a;
    logic       any_req;
    assign pick_a  = rda_req && (!rdb_req || rr_last);
    assign any_req = wr_req || rda_req || rdb_req;
    assign busy    = state != IDLE;
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            src          <= SRC_WR;
            cnt          <= '0;
            rr_last      <= 1'b1;
            bank_addr    <= '0;
            bank_wdata   <= '0;
            bank_trigger <= 1'b0;
            bank_rw      <= 1'b1;
            wr_ack       <= 1'b0;
            rda_ack      <= 1'b0;
            rdb_ack      <= 1'b0;
            rda_data     <= '0;
            rdb_data     <= '0;
        end else if (state == IDLE) begin
            if (any_req) begin
                bank_addr    <= wr_req ? wr_addr : pick_a ? rda_addr : rdb_addr;
                bank_rw      <= !wr_req;
                src          <= wr_req ? SRC_WR : pick_a ? SRC_A : SRC_B;
                bank_trigger <= !bank_trigger;
                cnt          <= CNT_INIT;
                state        <= WAIT;
                if (wr_req) bank_wdata <= wr_data;
                else rr_last <= !pick_a;
            end
        end else if (state == WAIT) begin
            if (cnt == 4'd0) begin
                wr_ack  <= src == SRC_WR;
                rda_ack <= src == SRC_A;
                rdb_ack <= src == SRC_B;
                if (src == SRC_A) rda_data <= bank_rdata;
                if (src == SRC_B) rdb_data <= bank_rdata;
                state <= ACK;
            end else begin
                cnt <= cnt - 4'd1;
            end
        end else begin
            wr_ack  <= 1'b0;
            rda_ack <= 1'b0;
            rdb_ack <= 1'b0;
            state   <= IDLE;
        end
    end
endmodule

// File: tb/tb_regbank_arbiter.sv
// tb_regbank_arbiter: directed checks of regbank_arbiter against a behavioural register bank
module tb_regbank_arbiter;
    logic        clk, rst;
    logic        wr_req, rda_req, rdb_req;
    logic [3:0]  wr_addr, rda_addr, rdb_addr;
    logic [31:0] wr_data;
    logic        wr_ack, rda_ack, rdb_ack;
    logic [31:0] rda_data, rdb_data;
    logic [3:0]  bank_addr;
    logic [31:0] bank_wdata, bank_rdata;
    logic        bank_trigger, bank_rw, busy;
    logic        rda1_req, rdb1_req;
    logic [3:0]  rda1_addr, rdb1_addr;
    logic        wr1_ack, rda1_ack, rdb1_ack;
    logic [31:0] rda1_data, rdb1_data;
    logic [3:0]  bank_addr1;
    logic [31:0] bank_wdata1, bank_rdata1;
    logic        bank_trigger1, bank_rw1, busy1;
    logic [31:0] mem [16];
    logic        trig0_q, trig1_q;
    int          tog1;
    int          checks, failures;

    regbank_arbiter #(.DATA_W(32), .ADDR_W(4), .BANK_LAT(2)) u_dut (
        .clk(clk), .rst(rst),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .rda_req(rda_req), .rda_addr(rda_addr), .rda_data(rda_data), .rda_ack(rda_ack),
        .rdb_req(rdb_req), .rdb_addr(rdb_addr), .rdb_data(rdb_data), .rdb_ack(rdb_ack),
        .bank_addr(bank_addr), .bank_wdata(bank_wdata), .bank_rdata(bank_rdata),
        .bank_trigger(bank_trigger), .bank_rw(bank_rw), .busy(busy)
    );

    regbank_arbiter #(.DATA_W(32), .ADDR_W(4), .BANK_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .wr_req(1'b0), .wr_addr(4'd0), .wr_data(32'd0), .wr_ack(wr1_ack),
        .rda_req(rda1_req), .rda_addr(rda1_addr), .rda_data(rda1_data), .rda_ack(rda1_ack),
        .rdb_req(rdb1_req), .rdb_addr(rdb1_addr), .rdb_data(rdb1_data), .rdb_ack(rdb1_ack),
        .bank_addr(bank_addr1), .bank_wdata(bank_wdata1), .bank_rdata(bank_rdata1),
        .bank_trigger(bank_trigger1), .bank_rw(bank_rw1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bank_rdata  = mem[bank_addr];
    assign bank_rdata1 = 32'h1000 + 32'(bank_addr1);

    always @(posedge clk) begin
        trig0_q <= bank_trigger;
        if (rst) begin
            for (int i = 0; i < 16; i++) mem[i] <= (i == 1) ? 32'd0 : 32'h1000 + 32'(i);
        end else if (bank_trigger != trig0_q && !bank_rw) begin
            mem[bank_addr] <= bank_wdata;
        end
    end

    initial tog1 = 0;
    always @(posedge clk) begin
        trig1_q <= bank_trigger1;
        if (bank_trigger1 != trig1_q) tog1 <= tog1 + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_ack(input int d, input logic [2:0] exp_v, input int exp_n, input string tag);
        int n;
        logic [2:0] v;
        n = 0;
        v = 3'b000;
        while (v == 3'b000 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
            v = (d == 0) ? {wr_ack, rda_ack, rdb_ack} : {wr1_ack, rda1_ack, rdb1_ack};
        end
        check({tag, " ack"}, 32'(v), 32'(exp_v));
        check({tag, " lat"}, 32'(n), 32'(exp_n));
        if (d == 0) begin
            if (v[2]) wr_req = 1'b0;
            if (v[1]) rda_req = 1'b0;
            if (v[0]) rdb_req = 1'b0;
        end else begin
            if (v[1]) rda1_req = 1'b0;
            if (v[0]) rdb1_req = 1'b0;
        end
    endtask

    initial begin
        int tog_start;
        checks = 0;
        failures = 0;
        rst = 1'b1;
        {wr_req, rda_req, rdb_req, rda1_req, rdb1_req} = '0;
        {wr_addr, rda_addr, rdb_addr, rda1_addr, rdb1_addr} = '0;
        wr_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst busy", 32'(busy), 32'd0);
        check("rst rw", 32'(bank_rw), 32'd1);
        check("rst trig", 32'(bank_trigger), 32'd0);
        check("rst acks", 32'({wr_ack, rda_ack, rdb_ack}), 32'd0);
        rst = 1'b0;
        // 1: single read of R1
        @(posedge clk); #1;
        rda_req = 1'b1; rda_addr = 4'd1;
        @(posedge clk); #1;
        check("t1 addr", 32'(bank_addr), 32'd1);
        check("t1 rw", 32'(bank_rw), 32'd1);
        check("t1 trig", 32'(bank_trigger), 32'd1);
        check("t1 busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        check("t1 early ack", 32'(rda_ack), 32'd0);
        @(posedge clk); #1;
        check("t1 ack", 32'(rda_ack), 32'd1);
        check("t1 data", rda_data, 32'd0);
        rda_req = 1'b0;
        @(posedge clk); #1;
        check("t1 ack pulse", 32'(rda_ack), 32'd0);
        check("t1 idle", 32'(busy), 32'd0);
        // 2: write R8 then read it back on port B
        wr_req = 1'b1; wr_addr = 4'd8; wr_data = 32'd8;
        @(posedge clk); #1;
        check("t2 rw", 32'(bank_rw), 32'd0);
        check("t2 wdata", bank_wdata, 32'd8);
        check("t2 addr", 32'(bank_addr), 32'd8);
        check("t2 trig", 32'(bank_trigger), 32'd0);
        wait_ack(0, 3'b100, 2, "t2 wr");
        @(posedge clk); #1;
        rdb_req = 1'b1; rdb_addr = 4'd8;
        wait_ack(0, 3'b001, 3, "t2 rd");
        check("t2 rdb_data", rdb_data, 32'd8);
        @(posedge clk); #1;
        // 3: simultaneous write and two reads
        wr_req = 1'b1; wr_addr = 4'd3; wr_data = 32'd5;
        rda_req = 1'b1; rda_addr = 4'd3;
        rdb_req = 1'b1; rdb_addr = 4'd2;
        wait_ack(0, 3'b100, 3, "t3 wr");
        wait_ack(0, 3'b010, 4, "t3 a");
        check("t3 rda_data", rda_data, 32'd5);
        wait_ack(0, 3'b001, 4, "t3 b");
        check("t3 rdb_data", rdb_data, 32'h1002);
        @(posedge clk); #1;
        // 4: both readers held -> strict alternation starting with A
        rda_req = 1'b1; rda_addr = 4'd4;
        rdb_req = 1'b1; rdb_addr = 4'd5;
        for (int i = 0; i < 4; i++) begin
            wait_ack(0, (i % 2 == 0) ? 3'b010 : 3'b001, 3, "t4 rr");
            if (i % 2 == 0) check("t4 rda_data", rda_data, 32'h1004);
            else check("t4 rdb_data", rdb_data, 32'h1005);
            if (i < 3) begin
                @(posedge clk); #1;
                if (i % 2 == 0) rda_req = 1'b1; else rdb_req = 1'b1;
            end
        end
        rda_req = 1'b0;
        @(posedge clk); #1;
        // 5: reset during WAIT of a read
        rda_req = 1'b1; rda_addr = 4'd6;
        @(posedge clk); #1;
        check("t5 busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("t5 acks", 32'({wr_ack, rda_ack, rdb_ack}), 32'd0);
        check("t5 rda_data", rda_data, 32'd0);
        check("t5 rdb_data", rdb_data, 32'd0);
        check("t5 addr", 32'(bank_addr), 32'd0);
        check("t5 trig", 32'(bank_trigger), 32'd0);
        check("t5 rw", 32'(bank_rw), 32'd1);
        check("t5 busy", 32'(busy), 32'd0);
        rst = 1'b0;
        wait_ack(0, 3'b010, 3, "t5 reserve");
        check("t5 data", rda_data, 32'h1006);
        @(posedge clk); #1;
        // 6: BANK_LAT=1 back-to-back reads, one toggle per access
        tog_start = tog1;
        rda1_req = 1'b1; rda1_addr = 4'd7;
        rdb1_req = 1'b1; rdb1_addr = 4'd9;
        for (int i = 0; i < 6; i++) begin
            wait_ack(1, (i % 2 == 0) ? 3'b010 : 3'b001, 2, "t6 b2b");
            if (i % 2 == 0) check("t6 rda_data", rda1_data, 32'h1007);
            else check("t6 rdb_data", rdb1_data, 32'h1009);
            if (i < 5) begin
                @(posedge clk); #1;
                if (i % 2 == 0) rda1_req = 1'b1; else rdb1_req = 1'b1;
            end
        end
        rda1_req = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("t6 toggles", 32'(tog1 - tog_start), 32'd6);
        check("t6 idle", 32'(busy1), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
